mem_bus_checker: RTL and testbench

MEM_BUS_CHECKER -- requirements
Module: mem_bus_checker

---
 rtl/chk_pkg.sv | 28 ++
 rtl/chk_match_sel.sv | 25 ++
 rtl/mem_bus_checker.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_checker.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
// Shared types for the memory-bus store checker: FSM state encoding, watch-table
// entry layout and the index-width helper used for table-index ports.
package chk_pkg;

    localparam int CHK_MAX_XLEN = 64;

    typedef logic [CHK_MAX_XLEN-1:0] chk_word_t;

    typedef enum logic [2:0] {
        CHK_IDLE    = 3'd0,
        CHK_RUN     = 3'd1,
        CHK_PASS    = 3'd2,
        CHK_FAIL    = 3'd3,
        CHK_TIMEOUT = 3'd4
    } chk_state_t;

    // Entries are stored at the widest supported bus width; narrower buses zero-extend.
    typedef struct packed {
        chk_word_t addr;
        chk_word_t data;
        logic      arm;
    } chk_entry_t;

    function automatic int chk_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/chk_match_sel.sv
// Priority encoder: reports the lowest set request bit and whether any bit is set.
module chk_match_sel
    import chk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]              i_req,
    output logic                          o_valid,
    output logic [chk_idx_w(DEPTH)-1:0]   o_idx
);

    localparam int IW = chk_idx_w(DEPTH);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downward so the lowest matching index is written last.
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (i_req[i-1]) begin
                o_idx = IW'(i - 1);
            end
        end
    end

endmodule

// File: rtl/mem_bus_checker.sv
// Watches bus stores against a programmable table of expected address/data pairs.
// Define CHK_STATS_EN to add saturating store/load cycle counters during RUN.
module mem_bus_checker
    import chk_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memwrite,
    input  logic [XLEN-1:0]              dataadr,
    input  logic [XLEN-1:0]              writedata,
    input  logic [XLEN-1:0]              pc,
    input  logic                         cfg_we,
    input  logic [chk_idx_w(DEPTH)-1:0]  cfg_idx,
    input  logic [XLEN-1:0]              cfg_addr,
    input  logic [XLEN-1:0]              cfg_data,
    input  logic                         cfg_arm,
    input  logic                         start,
    output chk_state_t                   state,
    output logic                         done,
    output logic                         pass,
    output logic [chk_idx_w(DEPTH)-1:0]  fail_idx,
    output logic [XLEN-1:0]              fail_pc,
    output logic [XLEN-1:0]              fail_data,
`ifdef CHK_STATS_EN
    output logic [31:0]                  store_count,
    output logic [31:0]                  load_count,
`endif
    output logic [31:0]                  cycle_count
);

    localparam int IW = chk_idx_w(DEPTH);

    chk_state_t       r_state, w_state_next;
    chk_entry_t       r_tab [DEPTH];
    logic [DEPTH-1:0] r_hit;
    logic [31:0]      r_cycles;
    logic [IW-1:0]    r_fail_idx;
    logic [XLEN-1:0]  r_fail_pc, r_fail_data;
    logic             r_done, r_pass;

    logic [DEPTH-1:0] w_cand, w_data_eq, w_arm, w_sel_onehot, w_hit_next;
    logic             w_sel_vld, w_run, w_mismatch, w_all_hit, w_timeout;
    logic [IW-1:0]    w_sel_idx;
    logic [31:0]      w_cycles_next;
    logic             w_done_next, w_pass_next;

    always_comb begin
        w_run     = (r_state == CHK_RUN);
        w_arm     = '0;
        w_data_eq = '0;
        w_cand    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_arm[i]     = r_tab[i].arm;
            w_data_eq[i] = (r_tab[i].data == chk_word_t'(writedata));
            w_cand[i]    = w_run && memwrite && r_tab[i].arm && !r_hit[i]
                           && (r_tab[i].addr == chk_word_t'(dataadr));
        end
    end

    chk_match_sel #(.DEPTH(DEPTH)) u_sel (
        .i_req   (w_cand),
        .o_valid (w_sel_vld),
        .o_idx   (w_sel_idx)
    );

    // Completion looks at the hit set including this cycle's store, so PASS lands
    // on the same edge that records the final hit.
    always_comb begin
        w_sel_onehot  = w_sel_vld ? (DEPTH'(1) << w_sel_idx) : '0;
        w_mismatch    = |(w_sel_onehot & ~w_data_eq);
        w_hit_next    = r_hit | (w_sel_onehot & w_data_eq);
        w_all_hit     = ((w_arm & ~w_hit_next) == '0);
        w_cycles_next = (r_cycles == '1) ? r_cycles : r_cycles + 32'd1;
        w_timeout     = (TIMEOUT_CYCLES != 0) && (w_cycles_next >= 32'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CHK_IDLE;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_pass  <= w_pass_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CHK_IDLE, CHK_PASS, CHK_FAIL, CHK_TIMEOUT: begin
                if (start) w_state_next = CHK_RUN;
            end
            CHK_RUN: begin
                if (w_mismatch)     w_state_next = CHK_FAIL;
                else if (w_all_hit) w_state_next = CHK_PASS;
                else if (w_timeout) w_state_next = CHK_TIMEOUT;
            end
            default: w_state_next = CHK_IDLE;
        endcase
    end

    always_comb begin
        w_done_next = (w_state_next == CHK_PASS) || (w_state_next == CHK_FAIL)
                      || (w_state_next == CHK_TIMEOUT);
        w_pass_next = (w_state_next == CHK_PASS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_tab[i] <= '0;
            end
            r_hit       <= '0;
            r_cycles    <= '0;
            r_fail_idx  <= '0;
            r_fail_pc   <= '0;
            r_fail_data <= '0;
        end else begin
            if (cfg_we && (r_state == CHK_IDLE) && (int'(cfg_idx) < DEPTH)) begin
                r_tab[cfg_idx].addr <= chk_word_t'(cfg_addr);
                r_tab[cfg_idx].data <= chk_word_t'(cfg_data);
                r_tab[cfg_idx].arm  <= cfg_arm;
            end
            if (start && !w_run) begin
                r_hit       <= '0;
                r_cycles    <= '0;
                r_fail_idx  <= '0;
                r_fail_pc   <= '0;
                r_fail_data <= '0;
            end else if (w_run) begin
                r_cycles <= w_cycles_next;
                r_hit    <= w_hit_next;
                if (w_mismatch) begin
                    r_fail_idx  <= w_sel_idx;
                    r_fail_pc   <= pc;
                    r_fail_data <= writedata;
                end
            end
        end
    end

`ifdef CHK_STATS_EN
    logic [31:0] r_stores, r_loads;

    always_ff @(posedge clk) begin
        if (reset || (start && !w_run)) begin
            r_stores <= '0;
            r_loads  <= '0;
        end else if (w_run) begin
            if (memwrite && (r_stores != '1)) r_stores <= r_stores + 32'd1;
            if (!memwrite && (r_loads != '1)) r_loads <= r_loads + 32'd1;
        end
    end

    assign store_count = r_stores;
    assign load_count  = r_loads;
`endif

    assign state       = r_state;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_idx    = r_fail_idx;
    assign fail_pc     = r_fail_pc;
    assign fail_data   = r_fail_data;
    assign cycle_count = r_cycles;

endmodule

// File: tb/tb_mem_bus_checker.sv
// Scenario bench for mem_bus_checker: expected terminal snapshots are queued as
// each run is launched and compared once the checker reports its result.
module tb_mem_bus_checker;
    import chk_pkg::*;

    logic        clk = 1'b0;
    logic        reset, memwrite, cfg_we, cfg_arm, start;
    logic [31:0] dataadr, writedata, pc, cfg_addr, cfg_data;
    logic [1:0]  cfg_idx;
    chk_state_t  state;
    logic        done, pass_o;
    logic [1:0]  fail_idx;
    logic [31:0] fail_pc, fail_data, cycle_count;

    typedef logic [102:0] snap_t;

    snap_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    mem_bus_checker #(
        .XLEN           (32),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .pc          (pc),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_arm     (cfg_arm),
        .start       (start),
        .state       (state),
        .done        (done),
        .pass        (pass_o),
        .fail_idx    (fail_idx),
        .fail_pc     (fail_pc),
        .fail_data   (fail_data),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(chk_state_t st, logic [1:0] idx, logic [31:0] fpc,
                                 logic [31:0] fdata, logic [31:0] cnt);
        logic term;
        term = (st == CHK_PASS) || (st == CHK_FAIL) || (st == CHK_TIMEOUT);
        return {st, term, (st == CHK_PASS), idx, fpc, fdata, cnt};
    endfunction

    function automatic snap_t obs();
        return {state, done, pass_o, fail_idx, fail_pc, fail_data, cycle_count};
    endfunction

    task automatic do_reset();
        reset = 1'b1; memwrite = 1'b0; cfg_we = 1'b0; start = 1'b0; cfg_arm = 1'b0;
        dataadr = '0; writedata = '0; pc = '0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic program_entry(input logic [1:0] idx, input logic [31:0] a,
                                 input logic [31:0] d, input logic arm);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d; cfg_arm = arm;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        memwrite = 1'b1; dataadr = a; writedata = d; pc = p;
        @(posedge clk); #1;
        memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int budget, output bit expired);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        expired = !done;
    endtask

    task automatic test_reset();
        snap_t e;
        do_reset();
        exp_q.push_back(mk(CHK_IDLE, 2'd0, 32'd0, 32'd0, 32'd0));
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_pass();
        snap_t e; bit x;
        do_reset();
        program_entry(2'd0, 32'd84, 32'd7, 1'b1);
        exp_q.push_back(mk(CHK_PASS, 2'd0, 32'd0, 32'd0, 32'd6));
        kick();
        idle(5);
        store(32'd84, 32'd7, 32'h10);
        wait_done(40, x);
        checks++;
        if (x) begin failures++; $display("FAIL pass_wait: done=%b expected 1", done); end
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL single_pass: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_fail();
        snap_t e; bit x;
        do_reset();
        program_entry(2'd0, 32'd84, 32'd7, 1'b1);
        exp_q.push_back(mk(CHK_FAIL, 2'd0, 32'h40, 32'd9, 32'd1));
        kick();
        store(32'd84, 32'd9, 32'h40);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL data_mismatch: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_same_addr_order();
        snap_t e; bit x;
        do_reset();
        program_entry(2'd0, 32'd100, 32'd1, 1'b1);
        program_entry(2'd1, 32'd100, 32'd2, 1'b1);
        exp_q.push_back(mk(CHK_PASS, 2'd0, 32'd0, 32'd0, 32'd2));
        kick();
        store(32'd100, 32'd1, 32'h80);
        store(32'd100, 32'd2, 32'h84);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL order_in_sequence: got %h expected %h", obs(), e);
        end
        exp_q.push_back(mk(CHK_FAIL, 2'd0, 32'h100, 32'd2, 32'd1));
        kick();
        store(32'd100, 32'd2, 32'h100);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL order_reversed: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_timeout();
        snap_t e; bit x;
        do_reset();
        program_entry(2'd0, 32'd84, 32'd7, 1'b1);
        exp_q.push_back(mk(CHK_TIMEOUT, 2'd0, 32'd0, 32'd0, 32'd10));
        kick();
        wait_done(40, x);
        checks++;
        if (x) begin failures++; $display("FAIL timeout_wait: done=%b expected 1", done); end
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL timeout: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_timeout_race();
        snap_t e; bit x;
        do_reset();
        program_entry(2'd0, 32'd84, 32'd7, 1'b1);
        exp_q.push_back(mk(CHK_PASS, 2'd0, 32'd0, 32'd0, 32'd10));
        kick();
        idle(9);
        store(32'd84, 32'd7, 32'h20);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL race_pass_vs_timeout: got %h expected %h", obs(), e);
        end
        exp_q.push_back(mk(CHK_FAIL, 2'd0, 32'h44, 32'd8, 32'd10));
        kick();
        idle(9);
        store(32'd84, 32'd8, 32'h44);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL race_fail_vs_timeout: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_zero_armed();
        snap_t e; bit x;
        do_reset();
        exp_q.push_back(mk(CHK_PASS, 2'd0, 32'd0, 32'd0, 32'd1));
        kick();
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL zero_armed: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_ignored_stores();
        snap_t e; bit x;
        do_reset();
        program_entry(2'd0, 32'd100, 32'd1, 1'b1);
        program_entry(2'd3, 32'd200, 32'd2, 1'b1);
        exp_q.push_back(mk(CHK_PASS, 2'd0, 32'd0, 32'd0, 32'd4));
        kick();
        store(32'd100, 32'd1, 32'h30);
        store(32'd100, 32'd5, 32'h34);
        store(32'd300, 32'd9, 32'h38);
        store(32'd200, 32'd2, 32'h3c);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL ignored_stores: got %h expected %h", obs(), e);
        end
    endtask

    // Runs from the terminal state left by test_ignored_stores, table retained.
    task automatic test_restart_cfg_locked();
        snap_t e; bit x;
        exp_q.push_back(mk(CHK_PASS, 2'd0, 32'd0, 32'd0, 32'd3));
        kick();
        program_entry(2'd1, 32'd50, 32'd5, 1'b1);
        store(32'd100, 32'd1, 32'h50);
        store(32'd200, 32'd2, 32'h54);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL restart_cfg_locked: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_start_in_run();
        snap_t e; bit x;
        do_reset();
        program_entry(2'd0, 32'd84, 32'd7, 1'b1);
        exp_q.push_back(mk(CHK_PASS, 2'd0, 32'd0, 32'd0, 32'd4));
        kick();
        idle(2);
        kick();
        store(32'd84, 32'd7, 32'h60);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL start_in_run: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_reset_mid_run();
        snap_t e; bit x;
        do_reset();
        program_entry(2'd0, 32'd84, 32'd7, 1'b1);
        kick();
        idle(3);
        exp_q.push_back(mk(CHK_IDLE, 2'd0, 32'd0, 32'd0, 32'd0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_mid_run: got %h expected %h", obs(), e);
        end
        idle(12);
        checks++;
        if (done !== 1'b0 || state !== CHK_IDLE) begin
            failures++;
            $display("FAIL reset_no_terminal: got done=%b state=%0d expected done=0 state=0",
                     done, state);
        end
        program_entry(2'd2, 32'd84, 32'd7, 1'b1);
        exp_q.push_back(mk(CHK_PASS, 2'd0, 32'd0, 32'd0, 32'd1));
        kick();
        store(32'd84, 32'd7, 32'h70);
        wait_done(40, x);
        e = exp_q.pop_front();
        checks++;
        if (x || obs() !== e) begin
            failures++;
            $display("FAIL cfg_after_reset: got %h expected %h", obs(), e);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_same_addr_order();
        test_timeout();
        test_timeout_race();
        test_zero_armed();
        test_ignored_stores();
        test_restart_cfg_locked();
        test_start_in_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
